// File: rtl/axis_pkg.sv
// Shared types and helpers for the AXI-Stream frame generator and its checkers.
package axis_pkg;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} gen_state_t;

  // Widest keep vector the helpers support (1024-bit data path).
  localparam int unsigned MAX_KW = 128;

  // Last-beat byte enables: low rem lanes set, or all kw lanes when rem is 0.
  function automatic logic [MAX_KW-1:0] keep_mask(input int unsigned rem, input int unsigned kw);
    logic [MAX_KW-1:0] m;
    int unsigned       n;
    n = (rem == 0) ? kw : rem;
    m = '0;
    for (int unsigned i = 0; i < MAX_KW; i++) begin
      m[i] = (i < n);
    end
    return m;
  endfunction

  function automatic logic [16:0] beats(input int unsigned len, input int unsigned kw);
    return 17'((len + kw - 1) / kw);
  endfunction

endpackage

// File: rtl/axis_if.sv
// AXI-Stream link bundle; the generator drives the master side.
interface axis_if #(
  parameter int DATA_WIDTH = 32,
  parameter int USER_WIDTH = 2
);
  localparam int KEEP_WIDTH = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] data;
  logic [KEEP_WIDTH-1:0] keep;
  logic                  last;
  logic [USER_WIDTH-1:0] user;
  logic                  valid;
  logic                  ready;

  modport master (output data, keep, last, user, valid, input ready);
  modport slave  (input data, keep, last, user, valid, output ready);
endinterface

// File: rtl/axis_pkt_gen.sv
// Frame generator: one incrementing-byte frame per start; beat 0 appears the cycle after start.
// Backpressure: every m_* output holds while m_valid & !m_ready; outputs are all registered.
module axis_pkt_gen
  import axis_pkg::*;
#(
  parameter int  DATA_WIDTH = 32,
  parameter int  USER_WIDTH = 2,
  localparam int KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [15:0]           len_bytes,
  input  logic [7:0]            seed,
  input  logic [USER_WIDTH-1:0] user_in,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [KEEP_WIDTH-1:0] m_keep,
  output logic                  m_last,
  output logic [USER_WIDTH-1:0] m_user,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           frame_count
);

  gen_state_t            state_q, state_d;
  logic [15:0]           len_q, len_d;
  logic [7:0]            seed_q, seed_d;
  logic [16:0]           off_q, off_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic [KEEP_WIDTH-1:0] m_keep_q, m_keep_d;
  logic                  m_last_q, m_last_d;
  logic [USER_WIDTH-1:0] m_user_q, m_user_d;
  logic                  m_valid_q, m_valid_d;
  logic                  done_q, done_d;
  logic [15:0]           frame_count_q, frame_count_d;

  // Next beat to present: beat 0 of a new frame from IDLE, else the beat after the current one.
  logic [15:0]           bt_len;
  logic [7:0]            bt_seed;
  logic [16:0]           bt_off;
  logic                  bt_last;
  logic [MAX_KW-1:0]     last_mask;
  logic [KEEP_WIDTH-1:0] bt_keep;
  logic [DATA_WIDTH-1:0] bt_data;

  always_comb begin
    bt_len    = (state_q == IDLE) ? len_bytes : len_q;
    bt_seed   = (state_q == IDLE) ? seed : seed_q;
    bt_off    = (state_q == IDLE) ? 17'd0 : off_q + 17'(KEEP_WIDTH);
    bt_last   = ({1'b0, bt_off} + 18'(KEEP_WIDTH)) >= {2'b00, bt_len};
    last_mask = keep_mask(int'(bt_len) % KEEP_WIDTH, KEEP_WIDTH);
    bt_keep   = bt_last ? last_mask[KEEP_WIDTH-1:0] : '1;
    bt_data   = '0;
    for (int k = 0; k < KEEP_WIDTH; k++) begin
      if (bt_keep[k]) begin
        bt_data[8*k +: 8] = bt_seed + bt_off[7:0] + 8'(k);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    seed_d        = seed_q;
    off_d         = off_q;
    m_data_d      = m_data_q;
    m_keep_d      = m_keep_q;
    m_last_d      = m_last_q;
    m_user_d      = m_user_q;
    m_valid_d     = m_valid_q;
    done_d        = 1'b0;
    frame_count_d = frame_count_q;
    case (state_q)
      IDLE: begin
        if (start && (len_bytes != 16'd0)) begin
          state_d   = SEND;
          len_d     = len_bytes;
          seed_d    = seed;
          off_d     = 17'd0;
          m_user_d  = user_in;
          m_valid_d = 1'b1;
          m_data_d  = bt_data;
          m_keep_d  = bt_keep;
          m_last_d  = bt_last;
        end
      end
      SEND: begin
        if (m_ready) begin
          if (m_last_q) begin
            state_d       = IDLE;
            m_valid_d     = 1'b0;
            m_data_d      = '0;
            m_keep_d      = '0;
            m_last_d      = 1'b0;
            m_user_d      = '0;
            done_d        = 1'b1;
            frame_count_d = frame_count_q + 16'd1;
          end else begin
            off_d    = bt_off;
            m_data_d = bt_data;
            m_keep_d = bt_keep;
            m_last_d = bt_last;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      len_q         <= '0;
      seed_q        <= '0;
      off_q         <= '0;
      m_data_q      <= '0;
      m_keep_q      <= '0;
      m_last_q      <= 1'b0;
      m_user_q      <= '0;
      m_valid_q     <= 1'b0;
      done_q        <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      seed_q        <= seed_d;
      off_q         <= off_d;
      m_data_q      <= m_data_d;
      m_keep_q      <= m_keep_d;
      m_last_q      <= m_last_d;
      m_user_q      <= m_user_d;
      m_valid_q     <= m_valid_d;
      done_q        <= done_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign m_data      = m_data_q;
  assign m_keep      = m_keep_q;
  assign m_last      = m_last_q;
  assign m_user      = m_user_q;
  assign m_valid     = m_valid_q;
  assign busy        = (state_q == SEND);
  assign done        = done_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Randomized bench for axis_pkt_gen: frames are predicted byte-by-byte from the stream rules.
module tb_axis_pkt_gen;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] len_bytes;
  logic [7:0]  seed;
  logic [1:0]  user_in;
  logic        busy;
  logic        done;
  logic [15:0] frame_count;

  axis_if #(.DATA_WIDTH(32), .USER_WIDTH(2)) ax ();

  axis_pkt_gen #(.DATA_WIDTH(32), .USER_WIDTH(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .len_bytes   (len_bytes),
    .seed        (seed),
    .user_in     (user_in),
    .m_data      (ax.data),
    .m_keep      (ax.keep),
    .m_last      (ax.last),
    .m_user      (ax.user),
    .m_valid     (ax.valid),
    .m_ready     (ax.ready),
    .busy        (busy),
    .done        (done),
    .frame_count (frame_count)
  );

  int          chk_pass  = 0;
  int          chk_total = 0;
  int          done_cnt  = 0;
  int          stall_cnt = 0;
  logic [15:0] model_cnt = 16'd0;
  logic        rdy_man_mode = 1'b1;
  logic        rdy_man = 1'b0;
  int unsigned rdy_pct = 100;
  logic [38:0] got_q[$];
  logic [38:0] exp_q[$];
  wire  [38:0] cur_beat = {ax.user, ax.last, ax.keep, ax.data};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_total++;
    if (obs === exp) chk_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Downstream ready, changed just after each rising edge.
  initial begin
    ax.ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_man_mode) ax.ready = rdy_man;
      else ax.ready = ($urandom_range(0, 99) < rdy_pct);
    end
  end

  // Stream monitor: records handshaked beats and checks that stalled beats stay put.
  initial begin
    logic        prev_stall;
    logic [38:0] prev_beat;
    prev_stall = 1'b0;
    prev_beat  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("hold_valid", ax.valid, 1);
          chk("hold_beat", cur_beat, prev_beat);
        end
        if (done) done_cnt++;
        if (ax.valid && ax.ready) got_q.push_back(cur_beat);
        if (ax.valid && !ax.ready) stall_cnt++;
        prev_stall = ax.valid && !ax.ready;
        prev_beat  = cur_beat;
      end
    end
  end

  task automatic run_frame(input int len, input logic [7:0] sd, input logic [1:0] us);
    int nb;
    int dc;
    int c;
    nb = (len + 3) / 4;
    exp_q.delete();
    for (int b = 0; b < nb; b++) begin
      logic [31:0] d;
      logic [3:0]  k;
      d = '0;
      k = '0;
      for (int l = 0; l < 4; l++) begin
        int idx;
        idx = b * 4 + l;
        if (idx < len) begin
          d[8*l +: 8] = 8'((int'(sd) + idx) % 256);
          k[l] = 1'b1;
        end
      end
      exp_q.push_back({us, (b == nb - 1), k, d});
    end
    got_q.delete();
    dc = done_cnt;
    @(posedge clk);
    #1;
    start = 1'b1; len_bytes = 16'(len); seed = sd; user_in = us;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("start_valid", ax.valid, 1);
    chk("start_busy", busy, 1);
    c = 0;
    while (!done && c < nb * 20 + 50) begin
      @(negedge clk);
      c++;
    end
    chk("done_seen", done, 1);
    if (done) begin
      model_cnt = model_cnt + 16'd1;
      chk("done_valid", ax.valid, 0);
      chk("done_busy", busy, 0);
      chk("frame_count", frame_count, model_cnt);
    end
    chk("nbeats", got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      chk("beat", got_q[i], exp_q[i]);
    end
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("done_count", done_cnt, dc + 1);
  endtask

  initial begin
    int   dc;
    logic saw_v;
    rst = 1'b1; start = 1'b0; len_bytes = '0; seed = '0; user_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", ax.valid, 0);
    chk("rst_last", ax.last, 0);
    chk("rst_data", ax.data, 0);
    chk("rst_keep", ax.keep, 0);
    chk("rst_user", ax.user, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_fcount", frame_count, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rdy_man = 1'b1;

    run_frame(8, 8'h10, 2'd2);
    run_frame(5, 8'hFE, 2'd1);

    // Three stall cycles on beat 1.
    stall_cnt = 0;
    fork
      run_frame(12, 8'h33, 2'd3);
      begin
        for (int c = 0; c < 50; c++) begin
          @(negedge clk);
          if (ax.valid && ax.ready) break;
        end
        rdy_man = 1'b0;
        repeat (4) @(posedge clk);
        rdy_man = 1'b1;
      end
    join
    chk("bp_stalls", stall_cnt, 3);

    // Zero-length start is dropped.
    dc = done_cnt;
    got_q.delete();
    saw_v = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b1; len_bytes = 16'd0;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (ax.valid) saw_v = 1'b1;
    end
    chk("zero_len_valid", saw_v, 0);
    chk("zero_len_done", done_cnt, dc);
    chk("zero_len_busy", busy, 0);

    // Start while sending is neither honoured nor queued.
    fork
      run_frame(16, 8'h40, 2'd0);
      begin
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1; len_bytes = 16'd8;
        @(posedge clk);
        #1;
        start = 1'b0;
      end
    join
    saw_v = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (ax.valid) saw_v = 1'b1;
    end
    chk("midframe_start", saw_v, 0);

    // Reset after beat 1 of a 16-byte frame.
    got_q.delete();
    dc = done_cnt;
    @(posedge clk);
    #1;
    start = 1'b1; len_bytes = 16'd16; seed = 8'h80; user_in = 2'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    model_cnt = 16'd0;
    chk("mid_rst_beats", got_q.size(), 2);
    chk("mid_rst_valid", ax.valid, 0);
    chk("mid_rst_last", ax.last, 0);
    chk("mid_rst_data", ax.data, 0);
    chk("mid_rst_keep", ax.keep, 0);
    chk("mid_rst_user", ax.user, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_fcount", frame_count, 0);
    chk("mid_rst_done", done_cnt, dc);
    run_frame(4, 8'hC3, 2'd2);

    // Random frames under random backpressure.
    rdy_man_mode = 1'b0;
    for (int f = 0; f < 25; f++) begin
      case ($urandom_range(0, 2))
        0:       rdy_pct = 100;
        1:       rdy_pct = 70;
        default: rdy_pct = 35;
      endcase
      run_frame(int'($urandom_range(1, 40)), 8'($urandom), 2'($urandom));
    end

    // Longest frame, then frame counter wrap.
    rdy_man_mode = 1'b1;
    rdy_man = 1'b1;
    run_frame(65535, 8'h5A, 2'd1);
    @(negedge clk);
    force dut.frame_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.frame_count_q;
    model_cnt = 16'hFFFF;
    run_frame(3, 8'h01, 2'd3);
    chk("fcount_wrap", frame_count, 0);

    $display("%0d/%0d checks passed", chk_pass, chk_total);
    $finish;
  end

endmodule

// File: doc/axis_pkt_gen.md
# axis_pkt_gen

AXI-Stream frame generator that drives the master side of an `axis_if` link into a downstream DUT or scoreboard path. On a start pulse it emits one frame of programmable byte length, with an incrementing byte pattern from a programmable seed and a constant user tag. It applies correct `keep` on the final partial beat and honours `ready` backpressure. It is the standard stimulus source for stream-based blocks.

## Interface

**Parameters**
- `DATA_WIDTH`, 32: stream data width in bits; multiple of 8, minimum 8.
- `USER_WIDTH`, 2: width of the `user` sideband.
- `KEEP_WIDTH`, derived, not overridable: `DATA_WIDTH/8`.

**Ports**
- `clk`, in, 1: clock; all logic on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: request one frame; sampled only in IDLE.
- `len_bytes`, in, 16: frame length in bytes; latched on an accepted start.
- `seed`, in, 8: value of byte 0 of the frame; latched on an accepted start.
- `user_in`, in, `USER_WIDTH`: tag driven on `m_user` for the whole frame; latched on an accepted start.
- `m_data`, out, `DATA_WIDTH`: stream data; byte lane 0 is bits [7:0].
- `m_keep`, out, `KEEP_WIDTH`: byte enables.
- `m_last`, out, 1: final beat of the frame.
- `m_user`, out, `USER_WIDTH`: frame tag.
- `m_valid`, out, 1: beat valid.
- `m_ready`, in, 1: downstream ready.
- `busy`, out, 1: high in SEND.
- `done`, out, 1: one-cycle pulse after the last beat handshakes.
- `frame_count`, out, 16: number of completed frames; wraps 0xFFFF to 0.

## Operation

- **States:** IDLE and SEND.
- **IDLE to SEND:** when `start` = 1 and `len_bytes` ≠ 0. On the same edge the block latches `len_bytes`, `seed` and `user_in`, and clears the byte offset.
- **Ignored starts:** `start` with `len_bytes` = 0 is ignored (no frame, no `done`). `start` in SEND is ignored and is not queued.
- **Beat count:** ceil(`len_bytes` / `KEEP_WIDTH`).
- **Data pattern:** frame byte i = (`seed` + i) mod 256 and is placed in lane (i mod `KEEP_WIDTH`) of beat floor(i / `KEEP_WIDTH`).
- **Keep:** all-ones on every beat except the last. On the last beat, `m_keep` has its low r bits set, where r = `len_bytes` mod `KEEP_WIDTH`, or all-ones if r = 0.
- **Unused lanes:** lanes with `m_keep` = 0 drive 0x00.
- **Last:** `m_last` = 1 only on the final beat.
- **Handshake:** a beat transfers when `m_valid` & `m_ready`.
  - While `m_valid` & !`m_ready`, all `m_*` outputs hold stable.
  - `m_valid` never drops without a handshake, except on reset.
- **SEND to IDLE:** on the handshake of the `m_last` beat.
  - Next cycle: `done` = 1, `frame_count` increments, `m_valid` = 0.
- **Byte offset:** internal offset is 17 bits, so a 65535-byte frame does not overflow.

## Timing

- **Outputs:** all outputs are registered; no combinational path from `m_ready` to any output.
- **Start latency:** `start` sampled at edge N gives `m_valid` = 1 with beat 0 after edge N.
- **Throughput:** with `m_ready` held high, one beat per cycle; a frame of B beats occupies B cycles of `m_valid`.
- **Frame gap:** minimum one idle cycle between frames. `start` sampled in the `done` cycle gives the next beat 0 on the following cycle.
- **Reset values** (any edge with `rst` = 1, including mid-frame): state IDLE, `m_valid` 0, `m_last` 0, `m_data` 0, `m_keep` 0, `m_user` 0, `busy` 0, `done` 0, `frame_count` 0. A partial frame is abandoned with no `m_last`.
- **`m_ready` while idle:** `m_ready` with `m_valid` = 0 has no effect.

## Structure

- **Package `axis_pkg`:**
  - state enum `gen_state_t` {IDLE, SEND};
  - function `keep_mask(rem, kw)` returning the last-beat keep;
  - function `beats(len, kw)` returning the ceiling divide.
- **Sub-module:** none. Beat formation, keep mask and FSM live in a single module; the package functions are shared with the checker.
- **Binding:** the generator's `m_*` ports bind to the `master` modport of an `axis_if` instance in the testbench.

## Test plan

All scenarios use `DATA_WIDTH` = 32.

1. **Full beats, no backpressure:** `len_bytes` = 8, `seed` = 0x10, `user_in` = 2, `m_ready` = 1 → exactly 2 beats. Data 0x13121110 then 0x17161514, `m_keep` 0xF on both, `m_last` on beat 2, `m_user` = 2. `done` pulses the next cycle; `frame_count` = 1.
2. **Partial last beat with seed wrap:** `len_bytes` = 5, `seed` = 0xFE → beat 0 0x0100FFFE with keep 0xF; beat 1 0x00000002 with keep 0x1 and `m_last` = 1.
3. **Backpressure:** `len_bytes` = 12, with `m_ready` low for 3 cycles during beat 1 → beat 1 outputs are constant for all 4 cycles, all 3 beats are delivered in order, and `done` pulses once.
4. **Ignored starts:**
   - `start` with `len_bytes` = 0 → no `m_valid`, no `done`.
   - `start` pulsed mid-frame → ignored; only one frame is produced.
5. **Reset mid-frame:** `rst` for 1 cycle after beat 1 of a 16-byte frame → all outputs at reset values the next cycle and `frame_count` = 0. A new `start` with `len_bytes` = 4 produces a single beat with `m_last` = 1.
6. **Maximum length and counter wrap:**
   - `len_bytes` = 0xFFFF → 16384 beats, last beat keep 0x7.
   - Force `frame_count` to 0xFFFF and complete one more frame → `frame_count` = 0.
